// File: rtl/rv32_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller and its decoder.
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } iclass_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/rv32_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct fields -> class, ALU op, immediate type, legality.
module rv32_ctrl_decode import rv32_ctrl_pkg::*; #(
  parameter bit SUPPORT_JUMPS = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output iclass_t    iclass,
  output logic [3:0] alu_sel,
  output logic [2:0] imm_sel,
  output logic       br_un,
  output logic       legal
);

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    iclass  = C_ALU_R;
    alu_sel = ALU_ADD;
    imm_sel = IMM_NONE;
    br_un   = 1'b0;
    legal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_sel = alu_from_f3(funct3);
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal   = 1'b1;
          alu_sel = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        iclass  = C_ALU_I;
        imm_sel = IMM_I;
        alu_sel = alu_from_f3(funct3);
        legal   = 1'b1;
        // Only the shift-immediates carry funct7 meaning; for the rest those bits are immediate.
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          if (funct7 == F7_ALT) alu_sel = ALU_SRA;
        end
      end
      OPC_LOAD: begin
        iclass  = C_LOAD;
        imm_sel = IMM_I;
        legal   = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
      end
      OPC_STORE: begin
        iclass  = C_STORE;
        imm_sel = IMM_S;
        legal   = !funct3[2] && (funct3[1:0] != 2'b11);
      end
      OPC_BRANCH: begin
        iclass  = C_BRANCH;
        imm_sel = IMM_B;
        br_un   = funct3[1];
        legal   = (funct3[2:1] != 2'b01);
      end
      OPC_JAL: begin
        iclass  = C_JAL;
        imm_sel = IMM_J;
        legal   = SUPPORT_JUMPS;
      end
      OPC_JALR: begin
        iclass  = C_JALR;
        imm_sel = IMM_I;
        legal   = SUPPORT_JUMPS && (funct3 == 3'b000);
      end
      OPC_LUI: begin
        iclass  = C_LUI;
        imm_sel = IMM_U;
        alu_sel = ALU_PASSB;
        legal   = SUPPORT_JUMPS;
      end
      OPC_AUIPC: begin
        iclass  = C_AUIPC;
        imm_sel = IMM_U;
        legal   = SUPPORT_JUMPS;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_controller.sv
// Multi-cycle RV32I control FSM: owns the IR, sequences FETCH/DECODE/EXEC/MEM/WB, traps on faults.
module rv32_multicycle_controller import rv32_ctrl_pkg::*; #(
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter bit          SUPPORT_JUMPS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_instruction,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        BrEq,
  input  logic        BrLt,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        MemRW,
  output logic [2:0]  mem_size,
  output logic [31:0] ir,
  output logic        PCWrite,
  output logic        PCSel,
  output logic [2:0]  ImmSel,
  output logic        BrUn,
  output logic        ASel,
  output logic        BSel,
  output logic [3:0]  ALUSel,
  output logic        RegWEn,
  output logic [1:0]  WBSel,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  state_t      state;
  logic [31:0] ir_q;
  logic [15:0] wait_cnt;
  logic [1:0]  cause_q;

  iclass_t     iclass;
  logic [3:0]  dec_alu;
  logic [2:0]  dec_imm;
  logic        dec_brun;
  logic        dec_legal;
  logic        taken;
  logic        limit;

  rv32_ctrl_decode #(.SUPPORT_JUMPS(SUPPORT_JUMPS)) u_decode (
    .opcode  (ir_q[6:0]),
    .funct3  (ir_q[14:12]),
    .funct7  (ir_q[31:25]),
    .iclass  (iclass),
    .alu_sel (dec_alu),
    .imm_sel (dec_imm),
    .br_un   (dec_brun),
    .legal   (dec_legal)
  );

  // funct3[2] picks the less-than flag over equality; funct3[0] inverts the sense.
  assign taken = (ir_q[14] ? BrLt : BrEq) ^ ir_q[12];
  // Limit is hit on the last stall cycle so that a ready arriving then still wins.
  assign limit = (MEM_TIMEOUT != 0) && (wait_cnt == 16'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ir_q     <= NOP;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            ir_q     <= i_instruction;
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (limit) begin
            cause_q <= CAUSE_IMEM_TO;
            state   <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_DECODE: begin
          if (!dec_legal) begin
            cause_q <= CAUSE_ILLEGAL;
            state   <= S_TRAP;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (iclass)
            C_BRANCH:        state <= S_FETCH;
            C_LOAD, C_STORE: state <= S_MEM;
            default:         state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            wait_cnt <= '0;
            state    <= (iclass == C_STORE) ? S_FETCH : S_WB;
          end else if (limit) begin
            cause_q <= CAUSE_DMEM_TO;
            state   <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    MemRW      = 1'b0;
    mem_size   = 3'd0;
    ir         = 32'd0;
    PCWrite    = 1'b0;
    PCSel      = 1'b0;
    ImmSel     = IMM_NONE;
    BrUn       = 1'b0;
    ASel       = 1'b0;
    BSel       = 1'b0;
    ALUSel     = ALU_ADD;
    RegWEn     = 1'b0;
    WBSel      = WB_MEM;
    trap       = (state == S_TRAP);
    trap_cause = cause_q;
    if (state != S_IDLE) begin
      ir       = ir_q;
      mem_size = ir_q[14:12];
    end
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC, S_MEM, S_WB: begin
        // Operand selects stay stable from EXEC through retirement.
        ImmSel = dec_imm;
        ALUSel = dec_alu;
        BrUn   = dec_brun;
        ASel   = (iclass == C_BRANCH) || (iclass == C_JAL) || (iclass == C_AUIPC);
        BSel   = (iclass != C_ALU_R);
        if (state == S_EXEC && iclass == C_BRANCH) begin
          PCWrite = 1'b1;
          PCSel   = taken;
        end
        if (state == S_MEM) begin
          dmem_req = 1'b1;
          MemRW    = (iclass == C_STORE);
          if (iclass == C_STORE && dmem_ready) PCWrite = 1'b1;
        end
        if (state == S_WB) begin
          PCWrite = 1'b1;
          RegWEn  = 1'b1;
          case (iclass)
            C_LOAD:         WBSel = WB_MEM;
            C_JAL, C_JALR: begin
              WBSel = WB_PC4;
              PCSel = 1'b1;
            end
            default:        WBSel = WB_ALU;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32_multicycle_controller.sv
// Randomized and directed bench for the multi-cycle controller against a behavioural instruction model.
module tb_rv32_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_instruction;
  logic        imem_ready, dmem_ready, BrEq, BrLt;

  logic        imem_req, dmem_req, MemRW, PCWrite, PCSel, BrUn, ASel, BSel, RegWEn, trap;
  logic [2:0]  mem_size, ImmSel;
  logic [31:0] ir;
  logic [3:0]  ALUSel;
  logic [1:0]  WBSel, trap_cause;

  logic        imem_req_nj, dmem_req_nj, MemRW_nj, PCWrite_nj, PCSel_nj, BrUn_nj, ASel_nj, BSel_nj;
  logic        RegWEn_nj, trap_nj;
  logic [2:0]  mem_size_nj, ImmSel_nj;
  logic [31:0] ir_nj;
  logic [3:0]  ALUSel_nj;
  logic [1:0]  WBSel_nj, trap_cause_nj;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rv32_multicycle_controller #(.MEM_TIMEOUT(16), .SUPPORT_JUMPS(1'b1)) dut (
    .clk(clk), .rst(rst), .i_instruction(i_instruction), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .BrEq(BrEq), .BrLt(BrLt), .imem_req(imem_req), .dmem_req(dmem_req),
    .MemRW(MemRW), .mem_size(mem_size), .ir(ir), .PCWrite(PCWrite), .PCSel(PCSel), .ImmSel(ImmSel),
    .BrUn(BrUn), .ASel(ASel), .BSel(BSel), .ALUSel(ALUSel), .RegWEn(RegWEn), .WBSel(WBSel),
    .trap(trap), .trap_cause(trap_cause));

  rv32_multicycle_controller #(.MEM_TIMEOUT(16), .SUPPORT_JUMPS(1'b0)) dut_nj (
    .clk(clk), .rst(rst), .i_instruction(i_instruction), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .BrEq(BrEq), .BrLt(BrLt), .imem_req(imem_req_nj), .dmem_req(dmem_req_nj),
    .MemRW(MemRW_nj), .mem_size(mem_size_nj), .ir(ir_nj), .PCWrite(PCWrite_nj), .PCSel(PCSel_nj),
    .ImmSel(ImmSel_nj), .BrUn(BrUn_nj), .ASel(ASel_nj), .BSel(BSel_nj), .ALUSel(ALUSel_nj),
    .RegWEn(RegWEn_nj), .WBSel(WBSel_nj), .trap(trap_nj), .trap_cause(trap_cause_nj));

  typedef struct packed {
    logic       legal;
    logic [3:0] lat;
    logic       is_mem;
    logic       is_store;
    logic       regwen;
    logic [1:0] wbsel;
    logic       pcsel;
    logic       brun;
    logic       chk_alu;
    logic [3:0] alu;
    logic       chk_imm;
    logic [2:0] imm;
    logic       chk_a;
    logic       asel;
    logic       chk_b;
    logic       bsel;
  } exp_t;

  localparam logic [31:0] ALU_TAB = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};

  // Expected retirement behaviour of one instruction, from the ISA rules.
  function automatic exp_t model(input logic [31:0] instr, input bit jumps, input logic eq, input logic lt);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [7:0] m;
    op = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
    e = '0;
    case (op)
      7'h33: begin
        e.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.lat = 4; e.regwen = 1; e.wbsel = 1;
        e.chk_alu = 1; e.alu = ALU_TAB[f3*4 +: 4] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
        e.chk_a = 1; e.chk_b = 1;
      end
      7'h13: begin
        if (f3 == 3'd1) e.legal = (f7 == 7'h00);
        else if (f3 == 3'd5) e.legal = (f7 == 7'h00) || (f7 == 7'h20);
        else e.legal = 1;
        e.lat = 4; e.regwen = 1; e.wbsel = 1;
        e.chk_alu = 1; e.alu = ALU_TAB[f3*4 +: 4] + ((f3 == 3'd5 && f7 == 7'h20) ? 4'd1 : 4'd0);
        e.chk_imm = 1; e.imm = 1; e.chk_a = 1; e.chk_b = 1; e.bsel = 1;
      end
      7'h03: begin
        m = 8'b0011_0111; e.legal = m[f3];
        e.lat = 5; e.is_mem = 1; e.regwen = 1; e.wbsel = 0;
      end
      7'h23: begin
        m = 8'b0000_0111; e.legal = m[f3];
        e.lat = 4; e.is_mem = 1; e.is_store = 1;
        e.chk_alu = 1; e.alu = 0; e.chk_imm = 1; e.imm = 2; e.chk_b = 1; e.bsel = 1;
      end
      7'h63: begin
        m = 8'b1111_0011; e.legal = m[f3];
        e.lat = 3; e.brun = f3[1];
        case (f3)
          3'd0: e.pcsel = eq;
          3'd1: e.pcsel = !eq;
          3'd4, 3'd6: e.pcsel = lt;
          default: e.pcsel = !lt;
        endcase
        e.chk_alu = 1; e.alu = 0; e.chk_imm = 1; e.imm = 3;
        e.chk_a = 1; e.asel = 1; e.chk_b = 1; e.bsel = 1;
      end
      7'h6f, 7'h67: begin
        e.legal = jumps && (op == 7'h6f || f3 == 3'd0);
        e.lat = 4; e.regwen = 1; e.wbsel = 2; e.pcsel = 1;
        e.chk_alu = 1; e.alu = 0; e.chk_imm = 1; e.imm = (op == 7'h6f) ? 3'd5 : 3'd1;
        e.chk_a = 1; e.asel = (op == 7'h6f); e.chk_b = 1; e.bsel = 1;
      end
      7'h37, 7'h17: begin
        e.legal = jumps;
        e.lat = 4; e.regwen = 1; e.wbsel = 1;
        e.chk_alu = 1; e.alu = (op == 7'h37) ? 4'd10 : 4'd0; e.chk_imm = 1; e.imm = 4;
        e.chk_a = 1; e.asel = (op == 7'h17); e.chk_b = 1; e.bsel = 1;
      end
      default: e.legal = 0;
    endcase
    return e;
  endfunction

  // Observations from the most recent run_instr call.
  int         o_cycles, o_pcw, o_rw_alone, o_dreq;
  logic       o_done, o_memrw, o_regwen, o_pcsel, o_brun, o_asel, o_bsel, o_trap;
  logic [1:0] o_wbsel, o_cause;
  logic [3:0] o_alu;
  logic [2:0] o_imm, o_msize;

  task automatic do_reset();
    rst = 1'b1; imem_ready = 0; dmem_ready = 0; BrEq = 0; BrLt = 0; i_instruction = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] instr, input int iw, input int dw, input logic eq, input logic lt);
    int fc, dc;
    bit started;
    fc = 0; dc = 0; started = 0;
    o_cycles = 0; o_pcw = 0; o_rw_alone = 0; o_dreq = 0; o_done = 0; o_memrw = 0;
    o_regwen = 0; o_pcsel = 0; o_brun = 0; o_asel = 0; o_bsel = 0; o_trap = 0;
    o_wbsel = 0; o_cause = 0; o_alu = 0; o_imm = 0; o_msize = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      i_instruction = instr; BrEq = eq; BrLt = lt;
      imem_ready = imem_req && (fc == iw);
      if (imem_req) begin fc++; started = 1; end
      dmem_ready = dmem_req && (dc == dw);
      if (dmem_req) begin dc++; o_dreq++; o_memrw = MemRW; end
      #1;
      if (started) o_cycles++;
      if (RegWEn && !PCWrite) o_rw_alone++;
      if (PCWrite) begin
        o_pcw++; o_done = 1; o_regwen = RegWEn; o_wbsel = WBSel; o_pcsel = PCSel; o_brun = BrUn;
        o_alu = ALUSel; o_imm = ImmSel; o_asel = ASel; o_bsel = BSel; o_msize = mem_size;
      end
      o_trap = trap; o_cause = trap_cause;
      if (PCWrite || trap) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 0; dmem_ready = 0; BrEq = 0; BrLt = 0; i_instruction = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if ({imem_req, dmem_req, PCWrite, RegWEn, trap} !== 5'b0) $display("FAIL reset_strobes: got %b required 00000", {imem_req, dmem_req, PCWrite, RegWEn, trap}); else n_pass++;
    n_chk++; if (trap_cause !== 2'd0) $display("FAIL reset_cause: got %0d required 0", trap_cause); else n_pass++;
    @(negedge clk); rst = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b0 || ir !== 32'h0) $display("FAIL reset_idle: got imem_req=%b ir=%h required 0/00000000", imem_req, ir); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || ir !== 32'h00000013) $display("FAIL reset_fetch: got imem_req=%b ir=%h required 1/00000013", imem_req, ir); else n_pass++;
  endtask

  task automatic test_alu_add();
    do_reset();
    run_instr(32'h002081B3, 0, 0, 0, 0);
    n_chk++; if (o_done !== 1'b1 || o_cycles !== 4) $display("FAIL add_cycles: got done=%b cycles=%0d required 1/4", o_done, o_cycles); else n_pass++;
    n_chk++; if ({o_regwen, o_wbsel, o_alu, o_pcsel} !== {1'b1, 2'd1, 4'd0, 1'b0}) $display("FAIL add_wb: got regwen=%b wbsel=%0d alu=%0d pcsel=%b required 1/1/0/0", o_regwen, o_wbsel, o_alu, o_pcsel); else n_pass++;
  endtask

  task automatic test_load_wait();
    do_reset();
    run_instr(32'h0080A183, 0, 3, 0, 0);
    n_chk++; if (o_dreq !== 4 || o_memrw !== 1'b0) $display("FAIL lw_dmem: got dmem_req cycles=%0d MemRW=%b required 4/0", o_dreq, o_memrw); else n_pass++;
    n_chk++; if ({o_regwen, o_wbsel, o_msize} !== {1'b1, 2'd0, 3'b010}) $display("FAIL lw_wb: got regwen=%b wbsel=%0d size=%0d required 1/0/2", o_regwen, o_wbsel, o_msize); else n_pass++;
    n_chk++; if (o_cycles !== 8) $display("FAIL lw_cycles: got %0d required 8", o_cycles); else n_pass++;
  endtask

  task automatic test_branch_bge();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      run_instr(32'h0020D463, 0, 0, 1'b0, k[0]);
      n_chk++; if (o_cycles !== 3 || o_pcsel !== !k[0]) $display("FAIL bge_%0d: got cycles=%0d pcsel=%b required 3/%b", k, o_cycles, o_pcsel, !k[0]); else n_pass++;
      n_chk++; if (o_regwen !== 1'b0 || o_rw_alone !== 0) $display("FAIL bge_regwen_%0d: got %b/%0d required 0/0", k, o_regwen, o_rw_alone); else n_pass++;
    end
  endtask

  task automatic test_jal();
    do_reset();
    run_instr(32'h008000EF, 0, 0, 0, 0);
    n_chk++; if ({o_regwen, o_wbsel, o_pcsel, o_imm, o_asel} !== {1'b1, 2'd2, 1'b1, 3'd5, 1'b1}) $display("FAIL jal_wb: got regwen=%b wbsel=%0d pcsel=%b imm=%0d asel=%b required 1/2/1/5/1", o_regwen, o_wbsel, o_pcsel, o_imm, o_asel); else n_pass++;
    n_chk++; if (trap_nj !== 1'b1 || trap_cause_nj !== 2'd1) $display("FAIL jal_nojump_trap: got trap=%b cause=%0d required 1/1", trap_nj, trap_cause_nj); else n_pass++;
    n_chk++; if ({imem_req_nj, dmem_req_nj, MemRW_nj, PCWrite_nj, PCSel_nj, RegWEn_nj} !== 6'b0) $display("FAIL jal_nojump_strobes: got %b required 000000", {imem_req_nj, dmem_req_nj, MemRW_nj, PCWrite_nj, PCSel_nj, RegWEn_nj}); else n_pass++;
  endtask

  task automatic test_fetch_timeout();
    int n;
    do_reset();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (imem_req) n++;
      if (trap) break;
    end
    n_chk++; if (n !== 16 || trap !== 1'b1 || trap_cause !== 2'd2) $display("FAIL imem_timeout: got fetch cycles=%0d trap=%b cause=%0d required 16/1/2", n, trap, trap_cause); else n_pass++;
    repeat (5) @(negedge clk);
    #1;
    n_chk++; if (trap !== 1'b1 || trap_cause !== 2'd2 || imem_req !== 1'b0) $display("FAIL imem_timeout_hold: got trap=%b cause=%0d req=%b required 1/2/0", trap, trap_cause, imem_req); else n_pass++;
    do_reset(); #1;
    n_chk++; if (trap !== 1'b0 || trap_cause !== 2'd0) $display("FAIL trap_clear: got trap=%b cause=%0d required 0/0", trap, trap_cause); else n_pass++;
    run_instr(32'h002081B3, 15, 0, 0, 0);
    n_chk++; if (o_trap !== 1'b0 || o_done !== 1'b1 || o_cycles !== 19) $display("FAIL imem_ready_at_limit: got trap=%b done=%b cycles=%0d required 0/1/19", o_trap, o_done, o_cycles); else n_pass++;
  endtask

  task automatic test_dmem_timeout();
    do_reset();
    run_instr(32'h0080A183, 0, 1000, 0, 0);
    n_chk++; if (o_trap !== 1'b1 || o_cause !== 2'd3 || o_dreq !== 16 || o_pcw !== 0) $display("FAIL dmem_timeout: got trap=%b cause=%0d dreq=%0d pcw=%0d required 1/3/16/0", o_trap, o_cause, o_dreq, o_pcw); else n_pass++;
  endtask

  task automatic test_reset_mid_store();
    bit seen;
    do_reset();
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      i_instruction = 32'h0020A223;
      imem_ready = imem_req; dmem_ready = dmem_req;
      #1;
      if (dmem_req) begin seen = 1; break; end
    end
    n_chk++; if (seen !== 1'b1 || PCWrite !== 1'b1) $display("FAIL sw_mem_reached: got seen=%b PCWrite=%b required 1/1", seen, PCWrite); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({dmem_req, PCWrite, RegWEn} !== 3'b0) $display("FAIL sw_reset_drop: got %b required 000", {dmem_req, PCWrite, RegWEn}); else n_pass++;
    @(negedge clk); rst = 1'b0; imem_ready = 0; dmem_ready = 0; #1;
    n_chk++; if (imem_req !== 1'b0 || ir !== 32'h0) $display("FAIL sw_reset_idle: got req=%b ir=%h required 0/00000000", imem_req, ir); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || ir !== 32'h00000013) $display("FAIL sw_reset_fetch: got req=%b ir=%h required 1/00000013", imem_req, ir); else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
    logic [31:0] instr;
    logic [4:0]  rop;
    exp_t        e;
    int          iw, dw, sel, total;
    logic        eq, lt;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      instr = $urandom;
      sel = $urandom_range(0, 9);
      rop = 5'($urandom_range(0, 31));
      instr[6:0] = (sel == 9) ? {rop, 2'b11} : ops[sel];
      case ($urandom_range(0, 3))
        0: instr[31:25] = 7'h00;
        1: instr[31:25] = 7'h20;
        default: ;
      endcase
      iw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      eq = 1'($urandom_range(0, 1)); lt = 1'($urandom_range(0, 1));
      e = model(instr, 1'b1, eq, lt);
      run_instr(instr, iw, dw, eq, lt);
      if (e.legal) begin
        total = e.lat + iw + (e.is_mem ? dw : 0);
        n_chk++; if (o_done !== 1'b1 || o_cycles !== total || o_pcw !== 1) $display("FAIL rnd_timing %h: got done=%b cycles=%0d pcw=%0d required 1/%0d/1", instr, o_done, o_cycles, o_pcw, total); else n_pass++;
        n_chk++; if ({o_regwen, o_wbsel, o_pcsel, o_brun} !== {e.regwen, e.wbsel, e.pcsel, e.brun} || o_rw_alone !== 0) $display("FAIL rnd_retire %h: got regwen=%b wbsel=%0d pcsel=%b brun=%b lone=%0d required %b/%0d/%b/%b/0", instr, o_regwen, o_wbsel, o_pcsel, o_brun, o_rw_alone, e.regwen, e.wbsel, e.pcsel, e.brun); else n_pass++;
        n_chk++; if ((e.chk_alu && o_alu !== e.alu) || (e.chk_imm && o_imm !== e.imm) || (e.chk_a && o_asel !== e.asel) || (e.chk_b && o_bsel !== e.bsel)) $display("FAIL rnd_operands %h: got alu=%0d imm=%0d asel=%b bsel=%b required %0d/%0d/%b/%b", instr, o_alu, o_imm, o_asel, o_bsel, e.alu, e.imm, e.asel, e.bsel); else n_pass++;
        n_chk++; if (o_dreq !== (e.is_mem ? dw + 1 : 0) || (e.is_mem && o_memrw !== e.is_store) || o_msize !== instr[14:12]) $display("FAIL rnd_mem %h: got dreq=%0d memrw=%b size=%0d required %0d/%b/%0d", instr, o_dreq, o_memrw, o_msize, e.is_mem ? dw + 1 : 0, e.is_store, instr[14:12]); else n_pass++;
      end else begin
        n_chk++; if (o_trap !== 1'b1 || o_cause !== 2'd1 || o_pcw !== 0) $display("FAIL rnd_illegal %h: got trap=%b cause=%0d pcw=%0d required 1/1/0", instr, o_trap, o_cause, o_pcw); else n_pass++;
        do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_load_wait();
    test_branch_bge();
    test_jal();
    test_fetch_timeout();
    test_dmem_timeout();
    test_reset_mid_store();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv32_multicycle_controller.md
Name: rv32_multicycle_controller

Overview:
Multi-cycle successor to the single-cycle RV32I controller. It owns the instruction register and a FETCH/DECODE/EXEC/MEM/WB state machine, and drives the existing datapath control signals (PCSel, ImmSel, BrUn, ASel, BSel, ALUSel, MemRW, RegWEn, WBSel). Instruction and data memory are reached through req/ready handshakes. It adds JAL, JALR, LUI, AUIPC, BGE/BGEU, wait-state tolerance, a memory timeout and an illegal-instruction trap.

Parameters:
MEM_TIMEOUT, 16, stall cycles allowed per memory request before trapping; 0 disables the timeout.
SUPPORT_JUMPS, 1, 1 decodes JAL/JALR/LUI/AUIPC; 0 treats them as illegal.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_instruction  in  32  imem read data, valid when imem_ready=1
imem_ready  in  1  instruction fetch complete
dmem_ready  in  1  data access complete
BrEq  in  1  comparator: rs1==rs2
BrLt  in  1  comparator: rs1<rs2 (unsigned when BrUn=1)
imem_req  out  1  fetch request
dmem_req  out  1  data request
MemRW  out  1  1=store, 0=load; meaningful only with dmem_req
mem_size  out  3  IR[14:12], the load/store size and sign
ir  out  32  instruction register, feeds immediate generator and regfile addresses
PCWrite  out  1  PC update strobe
PCSel  out  1  0=PC+4, 1=ALU result
ImmSel  out  3  1=I, 2=S, 3=B, 4=U, 5=J
BrUn  out  1  unsigned compare
ASel  out  1  0=rs1, 1=PC
BSel  out  1  0=rs2, 1=imm
ALUSel  out  4  0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and,10 passB
RegWEn  out  1  register write strobe
WBSel  out  2  0=mem, 1=ALU, 2=PC+4
trap  out  1  sticky fault flag
trap_cause  out  2  1=illegal instruction, 2=imem timeout, 3=dmem timeout

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. During and after reset: state=IDLE, ir=32'h00000013, timeout counter=0, trap=0, trap_cause=0.
- Outputs: all outputs are combinational from state and ir. In IDLE every output is 0.
- States: IDLE -> FETCH unconditionally on the next cycle.
- FETCH: imem_req=1. On imem_ready, ir<=i_instruction and go to DECODE. Otherwise stay in FETCH.
- DECODE: no strobes asserted. An unsupported opcode/funct3/funct7 combination goes to TRAP with cause 1. Otherwise go to EXEC.
- EXEC (R/I-ALU): drive ASel/BSel/ALUSel/ImmSel, then go to WB.
- EXEC (load/store): ALUSel=add, BSel=1, ImmSel=I for loads and S for stores, then go to MEM.
- EXEC (branch): ImmSel=B, ASel=1, BSel=1, ALUSel=add, PCWrite=1, then go to FETCH. PCSel=taken, where taken is: beq BrEq; bne !BrEq; blt BrLt; bge !BrLt; bltu/bgeu the same with BrUn=1.
- EXEC (JAL/JALR/LUI/AUIPC): go to WB.
- MEM: dmem_req=1, MemRW=1 for stores, address operands held stable. On dmem_ready, a load goes to WB; a store asserts PCWrite=1 with PCSel=0 and goes to FETCH.
- WB, ALU ops: RegWEn=1, WBSel=1.
- WB, load: RegWEn=1, WBSel=0.
- WB, LUI: ImmSel=U, BSel=1, ALUSel=10.
- WB, AUIPC: ASel=1, BSel=1, ALUSel=0.
- WB, JAL: RegWEn=1, WBSel=2, PCSel=1, ASel=1, BSel=1, ImmSel=J, ALUSel=0.
- WB, JALR: as JAL but ASel=0 and ImmSel=I.
- WB, all non-jump instructions: PCWrite=1 with PCSel=0. After WB go to FETCH.
- PCWrite: asserted exactly one cycle per retired instruction, and in the same cycle as RegWEn when both occur.
- Latency with zero-wait memory: branch 3 cycles; ALU/U-type/jump/store 4 cycles; load 5 cycles. Each cycle ready is low adds one cycle.
- Timeout counter: clears on entering FETCH or MEM and counts while req=1 and ready=0. When it reaches MEM_TIMEOUT (nonzero), go to TRAP with cause 2 (FETCH) or 3 (MEM). ready arriving in the same cycle as the limit is accepted; it is not a trap.
- TRAP: all strobes 0, trap=1, trap_cause held. TRAP is exited only by rst.
- Reset mid-operation: any strobe is dropped immediately (asynchronous). No partial PC or register write may occur after rst rises.

Decomposition:
- Shared package rv32_ctrl_pkg holds:
  - the state enum;
  - opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC;
  - ImmSel, ALUSel and WBSel encodings;
  - trap cause codes.
- One sub-module, rv32_ctrl_decode: combinational ir -> {class, ALUSel, ImmSel, BrUn, legal}. The FSM wraps it.

Test Plan:
- add x3,x1,x2 (0x002081B3), zero-wait memory -> 4 cycles; WB cycle shows RegWEn=1, WBSel=1, ALUSel=0, PCWrite=1, PCSel=0.
- lw with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles and MemRW=0; the WB cycle after that shows RegWEn=1, WBSel=0, mem_size=3'b010.
- bge with BrLt=0, then BrLt=1 -> 3 cycles each; EXEC shows PCWrite=1 with PCSel=1 then PCSel=0; RegWEn=0 throughout.
- jal x1,+8 (0x008000EF) -> WB shows RegWEn=1, WBSel=2, PCSel=1, ImmSel=5, ASel=1; with SUPPORT_JUMPS=0 -> trap=1, trap_cause=1.
- imem_ready held low, MEM_TIMEOUT=16 -> trap after 16 cycles in FETCH with trap_cause=2; stays there until rst; repeat with ready arriving on cycle 16 -> no trap.
- rst asserted in the MEM cycle of sw -> dmem_req, PCWrite, RegWEn drop the same cycle; after release the sequence is IDLE then FETCH with ir=0x00000013.
